// File: rtl/lc3b_mem_pkg.sv
// Shared types and encodings for the LC-3b memory data register / access sequencer.
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;
    localparam logic [1:0] WE_BOTH = 2'b11;

    // Byte lane enables for an active access; reads never enable a lane.
    function automatic logic [1:0] we_decode(input logic dir, input logic size, input logic addr0);
        if (dir == RW_READ) begin
            return WE_NONE;
        end
        if (size == SIZE_WORD) begin
            return WE_BOTH;
        end
        return addr0 ? WE_HI : WE_LO;
    endfunction

endpackage

// File: rtl/mdr_byte_sel.sv
// Byte select and sign extension of the MDR for the MDR bus gate and load-byte path.
module mdr_byte_sel
    import lc3b_mem_pkg::*;
(
    input  logic [15:0] mdr,
    input  logic        size,
    input  logic        addr0,
    output logic [15:0] mdr_out
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = addr0 ? mdr[15:8] : mdr[7:0];
        if (size == SIZE_WORD) begin
            mdr_out = mdr;
        end else begin
            mdr_out = {{8{sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/mem_mdr_unit.sv
// MDR ownership and memory read/write handshake; returns R to the control store.
//
// state  | meaning
// IDLE   | waiting for mio_en; ld_mdr honoured here only
// ACCESS | mem_en high, waiting for mem_ready or timeout
// DONE   | r high for one cycle, err qualifies it
module mem_mdr_unit
    import lc3b_mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        data_size,
    input  logic        ld_mdr,
    input  logic [15:0] mar,
    input  logic [15:0] bus_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] mdr_out,
    output logic        r,
    output logic        err,
    output logic        busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    mem_state_t       state;
    logic [15:0]      mdr;
    logic [15:0]      addr;
    logic             size;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            mdr   <= 16'h0000;
            addr  <= 16'h0000;
            size  <= SIZE_BYTE;
            dir   <= RW_READ;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_mdr) begin
                        mdr     <= (data_size == SIZE_WORD) ? bus_in : {bus_in[7:0], bus_in[7:0]};
                        size    <= data_size;
                        addr[0] <= mar[0];
                    end
                    if (mio_en) begin
                        addr <= mar;
                        size <= data_size;
                        dir  <= r_w;
                        cnt  <= '0;
                        // Unaligned word accesses never reach the memory array.
                        if (data_size == SIZE_WORD && mar[0]) begin
                            state <= DONE;
                            err_q <= 1'b1;
                        end else begin
                            state <= ACCESS;
                            err_q <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (dir == RW_READ) begin
                            mdr <= mem_rdata;
                        end
                        err_q <= 1'b0;
                        state <= DONE;
                    end else if (TIMEOUT_EN && cnt == CNT_LIMIT) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (TIMEOUT_EN) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign r         = (state == DONE);
    assign err       = r & err_q;
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en ? we_decode(dir, size, addr[0]) : WE_NONE;
    assign mem_addr  = {addr[15:1], 1'b0};
    assign mem_wdata = mdr;

    mdr_byte_sel u_byte_sel (
        .mdr     (mdr),
        .size    (size),
        .addr0   (addr[0]),
        .mdr_out (mdr_out)
    );

endmodule

// File: doc/mem_mdr_unit.md
# mem_mdr_unit

Memory data register and memory-access sequencer for the LC-3b datapath. It owns the 16-bit MDR and loads it either from the processor bus or from memory. It runs the read/write handshake to the memory array and returns R (ready) to the control store. Its `mdr_out` feeds the MDR bus gate directly, already byte-selected and sign-extended, so the gate stays a pure tristate driver.

## Interface
- `TIMEOUT`, 15: max ACCESS cycles waiting for `mem_ready`; 0 disables the timeout.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `mio_en` in 1: request a memory access (MIO.EN); held by control until `r`.
- `r_w` in 1: 0 = read, 1 = write.
- `data_size` in 1: 0 = byte, 1 = word.
- `ld_mdr` in 1: load MDR from `bus_in` (honoured in IDLE only).
- `mar` in 16: address from MAR.
- `bus_in` in 16: processor bus.
- `mem_rdata` in 16: memory read word.
- `mem_ready` in 1: memory completes the current access.
- `mem_en` out 1: memory access active.
- `mem_we` out 2: {WE1, WE0} byte write enables.
- `mem_addr` out 16: latched address, bit 0 forced to 0.
- `mem_wdata` out 16: current MDR value.
- `mdr_out` out 16: value offered to the MDR bus gate.
- `r` out 1: access complete, one cycle.
- `err` out 1: unaligned word access or timeout, valid with `r`.
- `busy` out 1: state is not IDLE.

## Operation
- **Reset values.** State IDLE; MDR = 0x0000; latched addr/size/dir = 0. All outputs 0.
- **IDLE, `ld_mdr` = 1.**
  - Word: MDR ← `bus_in`.
  - Byte: MDR ← {`bus_in[7:0]`, `bus_in[7:0]`}.
  - Latched size ← `data_size`; latched addr0 ← `mar[0]`.
- **IDLE, `mio_en` = 1.**
  - Latch `mar`, `r_w`, `data_size`.
  - Word with `mar[0]` = 1 (unaligned): go to DONE with `err` = 1; no memory cycle.
  - Otherwise go to ACCESS and clear the wait counter.
  - If `ld_mdr` is asserted on the same edge, it also applies; a write then uses the newly loaded MDR.
- **ACCESS.**
  - `mem_en` = 1; `mem_we` = 0 for reads.
  - Writes, word: `mem_we` = 11.
  - Writes, byte: `mem_we` = 01 if addr0 = 0, 10 if addr0 = 1.
  - On an edge with `mem_ready` = 1: a read sets MDR ← `mem_rdata` (full word); go to DONE with `err` = 0.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT` (nonzero), go to DONE with `err` = 1; MDR is unchanged.
- **DONE.** `r` = 1 for one cycle, then go to IDLE unconditionally. `mio_en` is not sampled in DONE.
- **`mdr_out`.**
  - Latched size word: MDR.
  - Latched size byte: sign-extend (addr0 ? MDR[15:8] : MDR[7:0]) to 16 bits.
- `ld_mdr` outside IDLE is ignored.
- A `mem_ready` pulse seen in IDLE or DONE is ignored.

## Timing
- **Request.** `mio_en` is sampled at edge k in IDLE. `mem_en`/`mem_we` are high from cycle k+1.
- **Minimum latency.** `mem_ready` high in the first ACCESS cycle gives `r` in cycle k+2. The MDR read value is visible on `mdr_out` in that same cycle.
- **Back-to-back.** If `mio_en` is still high in the IDLE cycle after DONE, a new access starts. Control must drop `mio_en` once it sees `r`.
- **Timeout.** With `TIMEOUT` = N, `r`/`err` arrive at cycle k+N+2.
- **Reset mid-access.** `reset_n` low at any edge gives IDLE, `mem_en` = 0 and MDR = 0 after that edge. No `r` pulse is produced.
- All outputs are registered or decoded from registered state; there is no combinational path from `mem_ready` to `r`.

## Structure
- **Package `lc3b_mem_pkg`:**
  - state enum {IDLE, ACCESS, DONE};
  - size constants SIZE_BYTE = 0, SIZE_WORD = 1;
  - direction constants RW_READ = 0, RW_WRITE = 1;
  - `mem_we` encodings WE_NONE, WE_LO, WE_HI, WE_BOTH.
- **Sub-module `mdr_byte_sel`:** combinational byte select plus sign extension producing `mdr_out`. It is reused later by the load-byte path.
- Counter width is $clog2(`TIMEOUT`+1), minimum 1.

## Test plan
- **Reset.** Drive traffic, then hold `reset_n` low for 1 edge → all outputs 0, `busy` = 0, `mdr_out` = 0x0000.
- **Word read.** `mar` = 0x3000, `mem_rdata` = 0xBEEF, `mem_ready` high 3 cycles after `mem_en` → `mem_addr` = 0x3000, `mem_we` = 00, `r` pulses once, `mdr_out` = 0xBEEF, `err` = 0.
- **Byte reads.**
  - `mar` = 0x3001, `mem_rdata` = 0x8042 → `mdr_out` = 0xFF80.
  - `mar` = 0x3000, same data → `mdr_out` = 0x0042.
- **Byte write.** `ld_mdr` with `bus_in` = 0x12A5, `data_size` = 0, `mar` = 0x4001, then write → `mem_wdata` = 0xA5A5, `mem_we` = 10, `mem_addr` = 0x4000.
- **Unaligned word write.** `mar` = 0x4003 → no `mem_en` at any cycle, `r` and `err` = 1 at k+1, MDR unchanged.
- **Timeout and reset.**
  - `TIMEOUT` = 4, `mem_ready` never asserted → `r` and `err` at k+6, MDR unchanged.
  - Separately, reset asserted in the 2nd ACCESS cycle → IDLE next cycle, no `r`.
